// File: rtl/arb_pkg.sv
// Shared definitions for the scalar/vector memory port arbiter:
// default widths, address stride between vector beats, FSM state
// encoding, grant tracking and a small index-width helper.
package arb_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int VLANES_DEFAULT = 8;
  localparam int ADDR_STRIDE    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_S_ACC  = 3'd1,
    ST_S_DONE = 3'd2,
    ST_V_ACC  = 3'd3,
    ST_V_DONE = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_SCALAR = 1'b0,
    GRANT_VECTOR = 1'b1
  } grant_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_serdes.sv
// Lane select/insert for vector bursts.
//   i_sel_idx / i_wvec -> o_sel_lane : write lane picked by beat index
//   i_cap_en / i_cap_idx / i_cap_data : store one read lane into o_rvec
//   rst_n : asynchronous active-low reset of the read-lane register
module lane_serdes
  import arb_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int VLANES = VLANES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [idx_w(VLANES)-1:0]   i_sel_idx,
  input  logic [DW*VLANES-1:0]       i_wvec,
  output logic [DW-1:0]              o_sel_lane,
  input  logic                       i_cap_en,
  input  logic [idx_w(VLANES)-1:0]   i_cap_idx,
  input  logic [DW-1:0]              i_cap_data,
  output logic [DW*VLANES-1:0]       o_rvec
);

  logic [DW*VLANES-1:0] r_rvec;

  assign o_sel_lane = i_wvec[int'(i_sel_idx)*DW +: DW];
  assign o_rvec     = r_rvec;

  // Read-lane capture: one lane per enabled cycle, others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvec <= '0;
    end else if (i_cap_en) begin
      r_rvec[int'(i_cap_idx)*DW +: DW] <= i_cap_data;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous single-port memory between a scalar
// requester (one access) and a vector requester (VLANES-beat burst).
//   s_* : scalar request/ack/data      v_* : vector request/ack/data
//   mem_* : shared memory port (read data valid one cycle after addr)
//   s_stall / v_stall : req and not ack     busy : FSM not in IDLE
//   reset : asynchronous, active-low
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int VLANES = VLANES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_req,
  input  logic                 s_we,
  input  logic [DW-1:0]        s_addr,
  input  logic [DW-1:0]        s_wdata,
  output logic [DW-1:0]        s_rdata,
  output logic                 s_ack,
  input  logic                 v_req,
  input  logic                 v_we,
  input  logic [DW-1:0]        v_addr,
  input  logic [DW*VLANES-1:0] v_wdata,
  output logic [DW*VLANES-1:0] v_rdata,
  output logic                 v_ack,
  output logic [DW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 s_stall,
  output logic                 v_stall,
  output logic                 busy
);

  localparam int              IW        = idx_w(VLANES);
  localparam int              VW        = DW * VLANES;
  localparam logic [IW-1:0]   LAST_BEAT = IW'(VLANES - 1);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  grant_t          r_last_grant;
  logic [IW-1:0]   r_beat;
  logic [DW-1:0]   r_addr;
  logic            r_we;
  logic [DW-1:0]   r_s_wdata;
  logic [VW-1:0]   r_v_wdata;
  logic [DW-1:0]   r_s_rdata;

  logic            w_grant_s;
  logic            w_grant_v;
  logic [DW-1:0]   w_beat_addr;
  logic [DW-1:0]   w_lane_wdata;
  logic            w_cap_en;
  logic [IW-1:0]   w_cap_idx;
  logic [VW-1:0]   w_v_rvec;

  // Base address is latched once; beats wrap modulo 2^DW.
  assign w_beat_addr = r_addr + (DW'(r_beat) * DW'(ADDR_STRIDE));

  lane_serdes #(
    .DW     (DW),
    .VLANES (VLANES)
  ) u_lane_serdes (
    .clk        (clk),
    .rst_n      (reset),
    .i_sel_idx  (r_beat),
    .i_wvec     (r_v_wdata),
    .o_sel_lane (w_lane_wdata),
    .i_cap_en   (w_cap_en),
    .i_cap_idx  (w_cap_idx),
    .i_cap_data (mem_rdata),
    .o_rvec     (w_v_rvec)
  );

  // Grant decision and next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_s   = 1'b0;
    w_grant_v   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_req && v_req) begin
          // Tie: serve whoever was not served last.
          if (r_last_grant == GRANT_VECTOR) begin
            w_grant_s = 1'b1;
          end else begin
            w_grant_v = 1'b1;
          end
        end else begin
          w_grant_s = s_req;
          w_grant_v = v_req;
        end
        if (w_grant_s) begin
          w_state_nxt = ST_S_ACC;
        end else if (w_grant_v) begin
          w_state_nxt = ST_V_ACC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_S_ACC:  w_state_nxt = ST_S_DONE;
      ST_S_DONE: w_state_nxt = ST_IDLE;
      ST_V_ACC: begin
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = ST_V_DONE;
        end else begin
          w_state_nxt = ST_V_ACC;
        end
      end
      ST_V_DONE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, request latches, beat counter and scalar read capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_VECTOR;
      r_beat       <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_s_wdata    <= '0;
      r_v_wdata    <= '0;
      r_s_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_s) begin
        r_addr       <= s_addr;
        r_we         <= s_we;
        r_s_wdata    <= s_wdata;
        r_last_grant <= GRANT_SCALAR;
      end else if (w_grant_v) begin
        r_addr       <= v_addr;
        r_we         <= v_we;
        r_v_wdata    <= v_wdata;
        r_last_grant <= GRANT_VECTOR;
      end
      if ((r_state == ST_V_ACC) && (r_beat != LAST_BEAT)) begin
        r_beat <= r_beat + IW'(1);
      end else begin
        r_beat <= '0;
      end
      if ((r_state == ST_S_DONE) && !r_we) begin
        r_s_rdata <= mem_rdata;
      end
    end
  end

  // Read data of beat k arrives one cycle later, so it lands in lane k-1
  // of the current beat; the final lane arrives during V_DONE.
  always_comb begin
    w_cap_en  = 1'b0;
    w_cap_idx = '0;
    if (r_we) begin
      w_cap_en = 1'b0;
    end else if (r_state == ST_V_DONE) begin
      w_cap_en  = 1'b1;
      w_cap_idx = LAST_BEAT;
    end else if ((r_state == ST_V_ACC) && (r_beat != '0)) begin
      w_cap_en  = 1'b1;
      w_cap_idx = r_beat - IW'(1);
    end else begin
      w_cap_en = 1'b0;
    end
  end

  // Memory port drive: only the access states touch the port.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      ST_S_ACC: begin
        mem_addr  = r_addr;
        mem_we    = r_we;
        mem_wdata = r_s_wdata;
      end
      ST_V_ACC: begin
        mem_addr  = w_beat_addr;
        mem_we    = r_we;
        mem_wdata = w_lane_wdata;
      end
      default: begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  // Read data is presented with the ack by passing the arriving word
  // through; the registered copy holds it afterwards.
  always_comb begin
    s_rdata = r_s_rdata;
    if ((r_state == ST_S_DONE) && !r_we) begin
      s_rdata = mem_rdata;
    end else begin
      s_rdata = r_s_rdata;
    end
  end

  // Same pass-through for the last vector lane.
  always_comb begin
    v_rdata = w_v_rvec;
    if ((r_state == ST_V_DONE) && !r_we) begin
      v_rdata[VW-1 -: DW] = mem_rdata;
    end else begin
      v_rdata = w_v_rvec;
    end
  end

  assign s_ack   = (r_state == ST_S_DONE);
  assign v_ack   = (r_state == ST_V_DONE);
  assign busy    = (r_state != ST_IDLE);
  assign s_stall = s_req & ~s_ack;
  assign v_stall = v_req & ~v_ack;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: memory word width.
REQ-002 SHALL have parameter VLANES, default 8: vector lanes; vector width = DW*VLANES (256).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset; asynchronous and active-low.
REQ-005 SHALL have ports s_req / s_we, input, 1 each: scalar access request and write enable.
REQ-006 SHALL have ports s_addr / s_wdata, input, DW each: scalar byte address and write data.
REQ-007 SHALL have ports s_rdata, output, DW, and s_ack, output, 1: scalar read data and completion pulse.
REQ-008 SHALL have ports v_req / v_we, input, 1 each: vector access request and write enable.
REQ-009 SHALL have ports v_addr, input, DW, and v_wdata, input, DW*VLANES: vector base address and lane data (lane i = bits 32i+31:32i).
REQ-010 SHALL have ports v_rdata, output, DW*VLANES, and v_ack, output, 1: vector read data and completion pulse.
REQ-011 SHALL have ports mem_addr, output, DW; mem_we, output, 1; mem_wdata, output, DW: the shared memory port.
REQ-012 SHALL have port mem_rdata, input, DW: synchronous read data, valid one cycle after the address.
REQ-013 SHALL have ports s_stall / v_stall, output, 1 each: req AND NOT ack, for use by the scalar and vector pipeline stall logic.
REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, S_ACC, S_DONE, V_ACC, V_DONE.
REQ-016 In IDLE with exactly one req high, SHALL grant that requester: scalar -> S_ACC, vector -> V_ACC.
REQ-017 In IDLE with both reqs high, SHALL grant the requester not granted last (round-robin); last_grant resets to vector, so scalar wins the first tie.
REQ-018 On grant, SHALL register addr, we and wdata; requester input changes after grant are ignored.
REQ-019 S_ACC, one cycle: SHALL drive mem_addr = latched s_addr, mem_we = latched s_we, mem_wdata = latched s_wdata; next state S_DONE.
REQ-020 S_DONE, one cycle: SHALL capture mem_rdata into s_rdata (reads only) and pulse s_ack = 1; next state IDLE.
REQ-021 Scalar latency: req seen in IDLE at cycle t -> s_ack at cycle t+2.
REQ-022 V_ACC SHALL last VLANES cycles, beat counter k = 0..VLANES-1: mem_addr = base + 4k (mod 2^DW, wraps), mem_wdata = lane k, mem_we = latched v_we.
REQ-023 Read data of beat k SHALL be stored in lane k of v_rdata on cycle k+1 of the burst; the last lane is stored in V_DONE.
REQ-024 V_DONE, one cycle: SHALL pulse v_ack = 1; next state IDLE; vector latency t -> t+VLANES+1 (t+9 at default).
REQ-025 The cycle after any DONE state is IDLE; a req still high there SHALL be treated as a new request.
REQ-026 mem_we SHALL be 0 in IDLE, S_DONE and V_DONE.
REQ-027 s_rdata and v_rdata SHALL hold their value until the next read completion of the same requester; writes leave them unchanged.
REQ-028 s_ack and v_ack SHALL never be high in the same cycle.

Reset
REQ-029 While reset = 0, SHALL set: state IDLE, beat counter 0, last_grant vector, mem_we 0, mem_addr 0, mem_wdata 0, s_ack 0, v_ack 0, s_rdata 0, v_rdata 0, busy 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no ack; beats already written are not undone.

Structure
REQ-031 A shared package arb_pkg SHALL hold the state enum, DW and VLANES defaults, and the ADDR_STRIDE = 4 constant.
REQ-032 Lane select/insert logic SHALL be one sub-module, lane_serdes (index k -> select write lane; capture read lane).

Verification
REQ-033 Scalar read s_addr=0x10, memory[0x10]=0xDEADBEEF -> mem_addr=0x10 at t+1; s_ack and s_rdata=0xDEADBEEF at t+2.
REQ-034 Vector write v_addr=0x100, lanes=1..8 -> mem_we=1 on addrs 0x100..0x11C with data 1..8 over 8 cycles; v_ack at t+9.
REQ-035 s_req and v_req rise together from reset -> scalar served first (ack t+2), vector granted at t+3; next tie grants scalar again.
REQ-036 Vector read v_addr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ..., 0x14 (wrap-around).
REQ-037 Reset pulled low at beat 3 of a vector write -> state IDLE, mem_we=0, no v_ack; a fresh s_req after release completes in 2 cycles.
REQ-038 v_addr changed during a burst -> addresses still follow the latched base; s_stall stays high for a scalar request waiting behind the burst.
